// File: rtl/apb_master_arbiter_pkg.sv
// Shared types for the APB master arbiter: protection type, FSM state encoding
// and a strobe-width helper.
package apb_master_arbiter_pkg;

    typedef logic [2:0] prot_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_mst_state_e;

    function automatic int strb_width(input int data_width);
        return (data_width + 7) / 8;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester channels plus APB4 master bus of the arbiter. The master modport is the
// arbiter's view; the slave modport is the environment's view (requesters + APB slave).
interface apb_master_arbiter_if
    import apb_master_arbiter_pkg::*;
#(
    parameter int NumReq    = 2,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) ();
    localparam int StrbWidth = strb_width(DataWidth);

    logic  [NumReq-1:0]                req_valid;
    logic  [NumReq-1:0]                req_ready;
    logic  [NumReq-1:0][AddrWidth-1:0] req_addr;
    logic  [NumReq-1:0]                req_write;
    logic  [NumReq-1:0][DataWidth-1:0] req_wdata;
    logic  [NumReq-1:0][StrbWidth-1:0] req_strb;
    prot_t [NumReq-1:0]                req_prot;

    logic  [NumReq-1:0]                rsp_valid;
    logic  [DataWidth-1:0]             rsp_rdata;
    logic                              rsp_slverr;

    logic  [AddrWidth-1:0]             paddr;
    prot_t                             pprot;
    logic                              psel;
    logic                              penable;
    logic                              pwrite;
    logic  [DataWidth-1:0]             pwdata;
    logic  [StrbWidth-1:0]             pstrb;
    logic                              pready;
    logic  [DataWidth-1:0]             prdata;
    logic                              pslverr;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
        output req_ready, rsp_valid, rsp_rdata, rsp_slverr,
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
        input  req_ready, rsp_valid, rsp_rdata, rsp_slverr,
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_master_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping.
// Produces a one-hot grant, its index and an any-valid flag.
module apb_rr_pick #(
    parameter  int NumReq = 2,
    localparam int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] valid,
    input  logic [IdxW-1:0]   ptr,
    output logic [NumReq-1:0] grant,
    output logic [IdxW-1:0]   idx,
    output logic              any
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NumReq; k++) begin
            j = int'(ptr) + k;
            if (j >= NumReq) j = j - NumReq;
            if (!any && valid[j]) begin
                any      = 1'b1;
                idx      = IdxW'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB4 master port between NumReq requesters;
// runs SETUP/ACCESS for the winner and returns rdata/slverr as a one-cycle pulse.
module apb_master_arbiter
    import apb_master_arbiter_pkg::*;
#(
    parameter int NumReq    = 2,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    apb_master_arbiter_if.master bus
);
    localparam int StrbWidth = strb_width(DataWidth);
    localparam int IdxW      = (NumReq > 1) ? $clog2(NumReq) : 1;

    apb_mst_state_e state, state_nxt;

    logic [NumReq-1:0]    grant;
    logic [IdxW-1:0]      win_idx;
    logic [IdxW-1:0]      rr_ptr;
    logic [IdxW-1:0]      owner;
    logic                 any_valid;
    logic                 accept;
    logic                 complete;
    logic [NumReq-1:0]    req_ready;

    logic [AddrWidth-1:0] paddr_q;
    prot_t                pprot_q;
    logic                 psel_q;
    logic                 penable_q;
    logic                 pwrite_q;
    logic [DataWidth-1:0] pwdata_q;
    logic [StrbWidth-1:0] pstrb_q;
    logic [NumReq-1:0]    rsp_valid_q;
    logic [DataWidth-1:0] rsp_rdata_q;
    logic                 rsp_slverr_q;

    apb_rr_pick #(.NumReq(NumReq)) u_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (any_valid)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // ready is gated by reset so nothing is handed out while the block is held in reset
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        complete  = 1'b0;
        req_ready = '0;
        case (state)
            ST_IDLE: begin
                if (any_valid && rst_ni) begin
                    accept    = 1'b1;
                    req_ready = grant;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (bus.pready) begin
                    complete  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            paddr_q      <= '0;
            pprot_q      <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            owner        <= '0;
            rr_ptr       <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            if (accept) begin
                paddr_q  <= bus.req_addr[win_idx];
                pprot_q  <= bus.req_prot[win_idx];
                pwrite_q <= bus.req_write[win_idx];
                pwdata_q <= bus.req_wdata[win_idx];
                pstrb_q  <= bus.req_write[win_idx] ? bus.req_strb[win_idx] : '0;
                owner    <= win_idx;
                rr_ptr   <= (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + 1'b1;
                psel_q   <= 1'b1;
            end
            if (state == ST_SETUP) penable_q <= 1'b1;
            if (complete) begin
                psel_q             <= 1'b0;
                penable_q          <= 1'b0;
                rsp_valid_q[owner] <= 1'b1;
                rsp_rdata_q        <= pwrite_q ? '0 : bus.prdata;
                rsp_slverr_q       <= bus.pslverr;
            end
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_slverr = rsp_slverr_q;
    assign bus.paddr      = paddr_q;
    assign bus.pprot      = pprot_q;
    assign bus.psel       = psel_q;
    assign bus.penable    = penable_q;
    assign bus.pwrite     = pwrite_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.pstrb      = pstrb_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a small APB slave model whose wait
// states, read data and error flag are set per test.
module tb_apb_master_arbiter;
    import apb_master_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_master_arbiter_if #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW)) bus ();

    apb_master_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    int          ws_cfg  = 0;
    logic [DW-1:0] prd_cfg = '0;
    logic        err_cfg = 1'b0;
    int          acc_cnt;

    // slave: pready rises after ws_cfg ACCESS cycles
    always @(posedge clk or negedge rst_n)
        if (!rst_n) acc_cnt <= 0;
        else if (bus.psel && bus.penable) acc_cnt <= bus.pready ? 0 : acc_cnt + 1;

    assign bus.pready  = bus.psel && bus.penable && (acc_cnt >= ws_cfg);
    assign bus.prdata  = prd_cfg;
    assign bus.pslverr = err_cfg;

    logic [N-1:0] pending;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) pending <= '0;
        else        pending <= (pending & ~bus.rsp_valid) | bus.req_ready;

    always @(negedge clk)
        if (rst_n)
            assert (!(|(pending & bus.req_valid & ~bus.rsp_valid)))
            else $error("requester raised valid while its transfer is outstanding");

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        bus.req_write[i] = wr;
        bus.req_addr[i]  = a;
        bus.req_wdata[i] = d;
        bus.req_strb[i]  = s;
        bus.req_prot[i]  = 3'(i + 1);
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic wait_rsp(input int i, input logic [DW-1:0] rd, input logic err, input string tag);
        int k;
        k = 0;
        while (bus.rsp_valid == '0 && k < 40) begin
            tick();
            k++;
        end
        chk({tag, "_timeout"}, 64'(k < 40), 64'd1);
        chk({tag, "_vld"}, 64'(bus.rsp_valid), 64'(1 << i));
        chk({tag, "_rdata"}, 64'(bus.rsp_rdata), 64'(rd));
        chk({tag, "_err"}, 64'(bus.rsp_slverr), 64'(err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        logic seen;
        int   w;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_write = '0;
        bus.req_wdata = '0;
        bus.req_strb  = '0;
        bus.req_prot  = '0;

        // reset state, with a pending request that must not be granted
        rst_n = 1'b0;
        bus.req_valid[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_psel", 64'(bus.psel), 64'd0);
        chk("rst_penable", 64'(bus.penable), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rspvld", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("rst_paddr", 64'(bus.paddr), 64'd0);
        bus.req_valid = '0;
        rst_n = 1'b1;
        tick();

        // single read from requester 0
        prd_cfg = 32'hDEADBEEF; err_cfg = 1'b0; ws_cfg = 0;
        set_req(0, 1'b0, 32'h100, 32'h0, 4'h0);
        #1 chk("t1_rdy", 64'(bus.req_ready), 64'b01);
        tick(); bus.req_valid[0] = 1'b0;
        chk("t1_setup", 64'({bus.psel, bus.penable}), 64'b10);
        chk("t1_paddr", 64'(bus.paddr), 64'h100);
        tick();
        chk("t1_access", 64'({bus.psel, bus.penable}), 64'b11);
        chk("t1_norsp", 64'(bus.rsp_valid), 64'd0);
        tick();
        chk("t1_rsp", 64'(bus.rsp_valid), 64'b01);
        chk("t1_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);
        chk("t1_err", 64'(bus.rsp_slverr), 64'd0);
        chk("t1_psel_off", 64'(bus.psel), 64'd0);
        tick();
        chk("t1_pulse", 64'(bus.rsp_valid), 64'd0);
        chk("t1_hold", 64'(bus.rsp_rdata), 64'hDEADBEEF);

        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

        // both requesters continuously valid: grants alternate 0,1,0,1,...
        set_req(0, 1'b0, 32'h200, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h300, 32'h0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            w = k % 2;
            prd_cfg = 32'h1000 + k;
            #1 chk("t2_grant", 64'(bus.req_ready), (w == 0) ? 64'b01 : 64'b10);
            tick(); bus.req_valid[w] = 1'b0;
            tick();
            tick();
            chk("t2_rsp", 64'(bus.rsp_valid), (w == 0) ? 64'b01 : 64'b10);
            chk("t2_rdata", 64'(bus.rsp_rdata), 64'(32'h1000 + k));
            bus.req_valid[w] = 1'b1;
        end
        bus.req_valid = '0;

        // write from requester 1 with 5 wait states
        ws_cfg = 5;
        tick();
        set_req(1, 1'b1, 32'h2004, 32'hCAFEF00D, 4'h5);
        #1 chk("t3_rdy", 64'(bus.req_ready), 64'b10);
        tick(); bus.req_valid[1] = 1'b0;
        chk("t3_setup", 64'({bus.psel, bus.penable}), 64'b10);
        chk("t3_prot", 64'(bus.pprot), 64'd2);
        tick();
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (bus.paddr !== 32'h2004 || bus.pwdata !== 32'hCAFEF00D || bus.pstrb !== 4'h5 ||
                bus.pwrite !== 1'b1 || {bus.psel, bus.penable} !== 2'b11 || bus.rsp_valid !== 2'b00)
                bad = 1'b1;
            tick();
        end
        chk("t3_stable", 64'(bad), 64'd0);
        chk("t3_rsp", 64'(bus.rsp_valid), 64'b10);
        chk("t3_rdata", 64'(bus.rsp_rdata), 64'd0);

        // read with slave error, then a clean write clears the error
        ws_cfg = 0; err_cfg = 1'b1; prd_cfg = 32'h0BADF00D;
        set_req(0, 1'b0, 32'h400, 32'h0, 4'h0);
        #1 chk("t4_rdy", 64'(bus.req_ready), 64'b01);
        tick(); bus.req_valid[0] = 1'b0;
        wait_rsp(0, 32'h0BADF00D, 1'b1, "t4_rd");
        err_cfg = 1'b0;
        set_req(1, 1'b1, 32'h404, 32'h11223344, 4'hF);
        #1 chk("t4w_rdy", 64'(bus.req_ready), 64'b10);
        tick(); bus.req_valid[1] = 1'b0;
        wait_rsp(1, 32'h0, 1'b0, "t4_wr");

        // read with strobes set must present pstrb=0
        prd_cfg = 32'h55AA55AA;
        set_req(0, 1'b0, 32'h500, 32'hFFFFFFFF, 4'hF);
        #1 chk("t5_rdy", 64'(bus.req_ready), 64'b01);
        tick(); bus.req_valid[0] = 1'b0;
        chk("t5_pstrb", 64'(bus.pstrb), 64'd0);
        chk("t5_pwrite", 64'(bus.pwrite), 64'd0);
        wait_rsp(0, 32'h55AA55AA, 1'b0, "t5");

        // reset during ACCESS: bus drops at once, no response, pointer back to 0
        ws_cfg = 10;
        set_req(0, 1'b0, 32'h600, 32'h0, 4'h0);
        #1 chk("t6_rdy", 64'(bus.req_ready), 64'b01);
        tick(); bus.req_valid[0] = 1'b0;
        tick();
        chk("t6_access", 64'({bus.psel, bus.penable}), 64'b11);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_bus", 64'({bus.psel, bus.penable}), 64'b00);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (bus.rsp_valid !== 2'b00 || bus.psel !== 1'b0) seen = 1'b1;
            tick();
        end
        chk("t6_norsp", 64'(seen), 64'd0);
        ws_cfg = 0; prd_cfg = 32'h77;
        set_req(0, 1'b0, 32'h700, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h704, 32'h0, 4'h0);
        #1 chk("t6_ptr0", 64'(bus.req_ready), 64'b01);
        tick(); bus.req_valid[0] = 1'b0;
        wait_rsp(0, 32'h77, 1'b0, "t6");
        bus.req_valid = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
